// File: rtl/rf_wport_arbiter.sv
// Register file write-port arbiter: pipeline writeback has priority,
// MDU results queue in a small FIFO and drain on idle writeback cycles.
module rf_wport_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     wp_en,
  output logic [4:0]               wp_addr,
  output logic [31:0]              wp_data,
  output logic [31:0]              pend_mask,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] LP_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] LP_LIMIT = SW'(STARVE_LIMIT);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_live;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [SW-1:0]    r_starve;
  logic             r_stall;

  logic             w_wb_active;
  logic             w_empty;
  logic             w_head_live;
  logic             w_pop;
  logic             w_pop_live;
  logic             w_push;
  logic [DEPTH-1:0] w_wr_oh;
  logic [DEPTH-1:0] w_rd_oh;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_live_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_stall_nxt;

  assign w_wb_active = wb_we && (wb_rd != 5'd0);
  assign w_empty     = (r_count == '0);
  assign w_head_live = !w_empty && r_live[r_rptr];

  assign mdu_ready = (r_count < LP_FULL);
  // x0 results are acknowledged but dropped here.
  assign w_push    = mdu_valid && mdu_ready && (mdu_rd != 5'd0);

  assign w_pop      = !w_wb_active && !w_empty;
  assign w_pop_live = w_pop && w_head_live;

  assign w_wr_oh = DEPTH'(1) << r_wptr;
  assign w_rd_oh = DEPTH'(1) << r_rptr;

  always_comb begin
    w_kill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_wb_active && r_live[k] && (r_rd[k] == wb_rd))
        w_kill[k] = 1'b1;
    end
  end

  // A same-cycle push is younger than the WB write, so it stays live.
  always_comb begin
    w_live_nxt = r_live & ~w_kill;
    if (w_pop)
      w_live_nxt = w_live_nxt & ~w_rd_oh;
    if (w_push)
      w_live_nxt = w_live_nxt | w_wr_oh;
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop)
      w_starve_nxt = '0;
    else if (w_head_live && w_wb_active && r_starve != LP_LIMIT)
      w_starve_nxt = r_starve + SW'(1);
  end

  always_comb begin
    w_stall_nxt = r_stall;
    if (w_empty || w_pop_live)
      w_stall_nxt = 1'b0;
    else if (w_starve_nxt == LP_LIMIT)
      w_stall_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_live   <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      r_count  <= w_count_nxt;
      r_live   <= w_live_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= w_stall_nxt;
    end
  end

  // Payload storage needs no reset; validity lives in r_count/r_live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= mdu_rd;
      r_data[r_wptr] <= mdu_data;
    end
  end

  always_comb begin
    wp_en   = 1'b0;
    wp_addr = 5'd0;
    wp_data = 32'd0;
    if (w_wb_active) begin
      wp_en   = 1'b1;
      wp_addr = wb_rd;
      wp_data = wb_data;
    end else if (w_head_live) begin
      wp_en   = 1'b1;
      wp_addr = r_rd[r_rptr];
      wp_data = r_data[r_rptr];
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_live[k])
        pend_mask[r_rd[k]] = 1'b1;
    end
  end

  assign stall_req  = r_stall;
  assign fifo_count = r_count;

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the register file's single write port between the pipeline writeback stage and the multi-cycle MDU (mul/div) result stream.
- Pipeline writeback always wins; MDU results wait in a small FIFO and drain on cycles when writeback is idle.
- Provides a pending-register mask so decode can stall on queued MDU destinations.
- Provides a starvation stall request so the FIFO cannot wait indefinitely.
- Sits between the WB stage / MDU and the register file write port, beside the decoder.

Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, minimum 2)
- STARVE_LIMIT, 8, consecutive blocked cycles with a non-empty FIFO before stall_req asserts

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wb_we  in  1  pipeline writeback valid
- wb_rd  in  5  pipeline writeback destination
- wb_data  in  32  pipeline writeback data
- mdu_valid  in  1  MDU result valid
- mdu_ready  out  1  FIFO can accept a result
- mdu_rd  in  5  MDU destination
- mdu_data  in  32  MDU result
- wp_en  out  1  register file write enable
- wp_addr  out  5  register file write address
- wp_data  out  32  register file write data
- pend_mask  out  32  bit i set = a live queued MDU write to xi exists
- stall_req  out  1  request that the pipeline hold WB idle for one cycle
- fifo_count  out  log2(DEPTH)+1  live plus dead entries currently held

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty, pointers and starvation counter cleared.
  - Outputs: stall_req=0, pend_mask=0, fifo_count=0, mdu_ready=1.
  - wp_* follow the WB inputs (x0 rule still applies).
- wb_active = wb_we && wb_rd!=0.
- Write port (combinational, zero latency):
  - If wb_active: wp_en=1, wp_addr=wb_rd, wp_data=wb_data.
  - Else if the FIFO head is valid and live: write the head, pop it.
  - Else if the head is dead (killed): pop it with wp_en=0.
  - Else wp_en=0, wp_addr=0, wp_data=0.
- MDU handshake:
  - mdu_ready = (fifo_count<DEPTH).
  - A push occurs on mdu_valid && mdu_ready.
  - A result with mdu_rd=0 is accepted but never enqueued.
  - Push and pop may occur in the same cycle; a push into a full FIFO coinciding with a pop is not allowed, because ready is computed from the registered count only.
- Empty FIFO: the MDU result is not bypassed. It writes no earlier than the cycle after the push.
- Ordering / kill:
  - When wb_active and entry k is live with rd==wb_rd, entry k's live bit clears at the clock edge. The younger pipeline write supersedes it.
  - An entry pushed in the same cycle with mdu_rd==wb_rd is enqueued live. The MDU result is the younger value.
- pend_mask: OR over live entries of one-hot(rd), computed from registered state. Duplicate rd entries are allowed; the bit stays set while any live entry remains.
- Starvation counter:
  - Increments each cycle the FIFO head is live and wb_active=1.
  - Clears on any pop or when the FIFO is empty; saturates at STARVE_LIMIT.
- stall_req (registered):
  - Sets when the counter reaches STARVE_LIMIT.
  - Clears the cycle after a live pop.
  - The pipeline guarantees wb_we=0 on cycles following stall_req=1.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Test Plan:
- Reset mid-drain:
  - Stimulus: 3 entries queued, assert rst asynchronously.
  - Required: fifo_count=0, pend_mask=0, stall_req=0 immediately, without waiting for a clock edge.
- Idle drain:
  - Stimulus: push rd=5 data=0x1234 with WB idle.
  - Required: next cycle wp_en=1, wp_addr=5, wp_data=0x1234; the following cycle pend_mask[5]=0.
- WB priority:
  - Stimulus: queued rd=7 while WB writes rd=3 for 2 cycles, then idles.
  - Required: wp_addr=3 twice, then 7.
- Kill:
  - Stimulus: queue rd=9=0xAAAA, then WB writes rd=9=0xBBBB.
  - Required: entry dies, pend_mask[9]=0, x9 is never written with 0xAAAA; the dead pop has wp_en=0.
- Full / x0:
  - Stimulus: DEPTH pushes with WB busy.
  - Required: mdu_ready=0, fifo_count=4.
  - Stimulus: push mdu_rd=0.
  - Required: fifo_count unchanged, no write.
- Starvation:
  - Stimulus: live head, WB busy continuously.
  - Required: stall_req=1 after 8 cycles; with WB then idle, the head pops and stall_req returns to 0 the next cycle.
